// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, buffer depth default, fetch entry.
// No logic; imported by the fetch top and its instruction buffer.
package if_fetch_pkg;

    localparam int BUF_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding fetched {pc,inst} entries for decode.
// Latency: a push is visible at the head one cycle later; head data is a direct read.
// Backpressure: push ignored when full, pop ignored when empty; flush empties in one cycle.
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DEF,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  fetch_entry_t      push_dat,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output fetch_entry_t      head_dat
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Stale storage is left in place; only the pointers define occupancy.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem read at a time, results buffered toward decode.
// Latency: request issues the cycle after IDLE; ack pushes and pulses pc_adv in the same cycle.
// Backpressure: no new request while the buffer is full; redirect flushes and drops in-flight data.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_adv,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    fetch_state_t   state;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   push_dat;
    fetch_entry_t   head_dat;

    always_comb begin
        fifo_flush = !rst && redirect;
        fifo_push  = !rst && !redirect && (state == WAIT) && imem_ack && !fifo_full;
        fifo_pop   = !rst && !redirect && id_valid && id_ready;
        pc_adv     = fifo_push;
        push_dat   = '{pc: imem_addr, inst: imem_rdata};
    end

    assign id_valid = !fifo_empty;
    assign id_inst  = head_dat.inst;
    assign id_pc    = head_dat.pc;

    // imem_req tracks WAIT/DROP exactly, so an ack seen in IDLE never reaches the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!redirect && (fifo_count < CW'(BUF_DEPTH))) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_in & 32'hFFFF_FFFC;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_dat (head_dat)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch scenarios, expected entries queued up front,
// a negedge monitor pops and compares every entry decode accepts.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_adv;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    // upstream PC register and memory responder controls
    logic [31:0] pc_q;
    logic [31:0] redir_pc;
    logic [31:0] rst_pc;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic        auto_ack;
    logic [31:0] auto_rdata;
    int          acks_left;
    int          mem_lat;
    int          req_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    int          adv_cnt = 0;
    int          adv_snap;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    if_fetch #(.BUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_adv     (pc_adv),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc)
    );

    assign pc_in      = pc_q;
    assign imem_ack   = auto_ack | man_ack;
    assign imem_rdata = auto_ack ? auto_rdata : man_rdata;

    always @(posedge clk) begin
        if (rst)           pc_q <= rst_pc;
        else if (redirect) pc_q <= redir_pc;
        else if (pc_adv)   pc_q <= pc_q + 32'd4;
    end

    // Memory: acks mem_lat cycles after the first WAIT cycle, while acks_left allows.
    initial begin
        auto_ack   = 1'b0;
        auto_rdata = '0;
        req_cnt    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) req_cnt++;
            else          req_cnt = 0;
            if (imem_req && acks_left > 0 && req_cnt > mem_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = {16'hC0DE, imem_addr[15:0]};
                acks_left--;
                req_cnt    = 0;
            end else begin
                auto_ack = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pc_adv) adv_cnt++;
            if (id_valid && id_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %h inst %h expected none", id_pc, id_inst);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", id_pc, e[63:32]);
                    chk("sb_inst", id_inst, e[31:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    task automatic wait_req(input string nm);
        for (int k = 0; k < 100 && imem_req !== 1'b1; k++) tick(1);
        chk(nm, {31'd0, imem_req}, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 100 && imem_req !== 1'b0; k++) tick(1);
        chk(nm, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
        chk(nm, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst    = 1'b1;
        rst_pc = start_pc;
        tick(2);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redir_pc = '0; rst_pc = '0;
        id_ready = 1'b1; man_ack = 1'b0; man_rdata = '0;
        acks_left = 0; mem_lat = 1;

        // Reset state and basic fetch with one-cycle memory
        tick(3);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_adv", {31'd0, pc_adv}, 32'd0);
        chk("reset_valid", {31'd0, id_valid}, 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_inst", id_inst, 32'd0);
        chk("reset_pc", id_pc, 32'd0);
        acks_left = 2;
        expect_entry(32'h0000_0000, 32'hC0DE_0000);
        expect_entry(32'h0000_0004, 32'hC0DE_0004);
        adv_snap = adv_cnt;
        rst = 1'b0;
        wait_req("t1_req0");
        chk("t1_addr0", imem_addr, 32'h0000_0000);
        wait_idle("t1_ack0");
        wait_req("t1_req1");
        chk("t1_addr1", imem_addr, 32'h0000_0004);
        chk("t1_adv_once", adv_cnt - adv_snap, 32'd1);
        wait_drain("t1_drain");
        wait_req("t1_req2");
        chk("t1_addr2", imem_addr, 32'h0000_0008);
        chk("t1_adv_twice", adv_cnt - adv_snap, 32'd2);

        // Decode stalled, zero-wait memory: buffer fills to two and fetching stops
        id_ready = 1'b0;
        do_reset(32'h0);
        mem_lat = 0; acks_left = 10;
        expect_entry(32'h0000_0000, 32'hC0DE_0000);
        expect_entry(32'h0000_0004, 32'hC0DE_0004);
        adv_snap = adv_cnt;
        tick(12);
        chk("t2_req_stop", {31'd0, imem_req}, 32'd0);
        chk("t2_valid", {31'd0, id_valid}, 32'd1);
        chk("t2_head_pc", id_pc, 32'h0000_0000);
        chk("t2_head_inst", id_inst, 32'hC0DE_0000);
        chk("t2_adv", adv_cnt - adv_snap, 32'd2);
        acks_left = 2;
        expect_entry(32'h0000_0008, 32'hC0DE_0008);
        expect_entry(32'h0000_000C, 32'hC0DE_000C);
        id_ready = 1'b1;
        wait_drain("t2_drain");
        wait_req("t2_resume");
        chk("t2_resume_addr", imem_addr, 32'h0000_0010);

        // Redirect while waiting, late ack must be dropped
        do_reset(32'h0);
        mem_lat = 1; acks_left = 0;
        wait_req("t3_req");
        chk("t3_addr", imem_addr, 32'h0000_0000);
        adv_snap = adv_cnt;
        redirect = 1'b1; redir_pc = 32'h0000_0100;
        tick(1);
        redirect = 1'b0;
        chk("t3_drop_req", {31'd0, imem_req}, 32'd1);
        chk("t3_drop_valid", {31'd0, id_valid}, 32'd0);
        tick(2);
        man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick(1);
        man_ack = 1'b0;
        chk("t3_idle_req", {31'd0, imem_req}, 32'd0);
        chk("t3_no_push", {31'd0, id_valid}, 32'd0);
        chk("t3_no_adv", adv_cnt - adv_snap, 32'd0);
        acks_left = 1;
        expect_entry(32'h0000_0100, 32'hC0DE_0100);
        wait_req("t3_req_tgt");
        chk("t3_addr_tgt", imem_addr, 32'h0000_0100);
        wait_drain("t3_drain");

        // Redirect coincident with ack
        wait_req("t4_req");
        chk("t4_addr", imem_addr, 32'h0000_0104);
        adv_snap = adv_cnt;
        redirect = 1'b1; redir_pc = 32'h0000_0300;
        man_ack = 1'b1; man_rdata = 32'h1111_1111;
        tick(1);
        redirect = 1'b0; man_ack = 1'b0;
        chk("t4_idle", {31'd0, imem_req}, 32'd0);
        chk("t4_no_push", {31'd0, id_valid}, 32'd0);
        acks_left = 1;
        expect_entry(32'h0000_0300, 32'hC0DE_0300);
        wait_req("t4_req_tgt");
        chk("t4_addr_tgt", imem_addr, 32'h0000_0300);
        chk("t4_no_adv", adv_cnt - adv_snap, 32'd0);
        wait_drain("t4_drain");

        // One entry held, pop and push in the same cycle
        id_ready = 1'b0;
        do_reset(32'h0);
        mem_lat = 0; acks_left = 1;
        expect_entry(32'h0000_0000, 32'hC0DE_0000);
        for (int k = 0; k < 50 && !(id_valid === 1'b1 && imem_req === 1'b1); k++) tick(1);
        chk("t5_valid", {31'd0, id_valid}, 32'd1);
        chk("t5_addr", imem_addr, 32'h0000_0004);
        chk("t5_head0", id_pc, 32'h0000_0000);
        expect_entry(32'h0000_0004, 32'hC0DE_0004);
        id_ready = 1'b1; man_ack = 1'b1; man_rdata = 32'hC0DE_0004;
        tick(1);
        id_ready = 1'b0; man_ack = 1'b0;
        chk("t5_valid_kept", {31'd0, id_valid}, 32'd1);
        chk("t5_head_pc", id_pc, 32'h0000_0004);
        chk("t5_head_inst", id_inst, 32'hC0DE_0004);
        tick(1);
        chk("t5_count_one", {31'd0, id_valid}, 32'd1);
        id_ready = 1'b1;
        wait_drain("t5_drain");

        // Reset mid-WAIT, then a stray ack with no request outstanding
        wait_req("t6_req");
        chk("t6_addr", imem_addr, 32'h0000_0008);
        adv_snap = adv_cnt;
        rst = 1'b1; rst_pc = 32'h0000_0200;
        tick(1);
        rst = 1'b0; man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
        chk("t6_req0", {31'd0, imem_req}, 32'd0);
        chk("t6_adv0", {31'd0, pc_adv}, 32'd0);
        chk("t6_addr0", imem_addr, 32'd0);
        chk("t6_pc0", id_pc, 32'd0);
        chk("t6_inst0", id_inst, 32'd0);
        tick(1);
        man_ack = 1'b0;
        chk("t6_no_push", {31'd0, id_valid}, 32'd0);
        chk("t6_req_new", {31'd0, imem_req}, 32'd1);
        chk("t6_addr_new", imem_addr, 32'h0000_0200);
        chk("t6_no_adv", adv_cnt - adv_snap, 32'd0);
        mem_lat = 1; acks_left = 1;
        expect_entry(32'h0000_0200, 32'hC0DE_0200);
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer depth in entries; only the value 2 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port pc_in  input  32  current PC from the PC register.
REQ-005 SHALL have port pc_adv  output  1  one-cycle pulse; upstream loads PC+4 on the next edge.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; flush the block; upstream loads the target PC on the same edge.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  32  word-aligned read address.
REQ-009 SHALL have port imem_ack  input  1  read complete; imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-011 SHALL have port id_valid  output  1  id_inst/id_pc valid toward decode.
REQ-012 SHALL have port id_ready  input  1  decode accepts the entry this cycle.
REQ-013 SHALL have port id_inst  output  32  instruction at the FIFO head.
REQ-014 SHALL have port id_pc  output  32  PC of the FIFO head instruction.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and DROP.
REQ-016 IDLE->WAIT SHALL occur when rst=0, redirect=0 and FIFO count < BUF_DEPTH; imem_req SHALL be 1 in WAIT and DROP only.
REQ-017 SHALL register imem_addr as {pc_in[31:2],2'b00} on entry to WAIT and hold it stable until ack; pc_in[1:0] are ignored.
REQ-018 In WAIT, imem_ack=1 with redirect=0 SHALL push {pc,imem_rdata} into the FIFO, pulse pc_adv in that same cycle, and return to IDLE.
REQ-019 There SHALL be at most one outstanding request; the minimum issue interval is 2 cycles (IDLE, WAIT).
REQ-020 redirect=1 in IDLE SHALL clear the FIFO; id_valid SHALL be 0 next cycle.
REQ-021 redirect=1 in WAIT without ack SHALL clear the FIFO and go to DROP.
REQ-022 redirect=1 in WAIT with ack SHALL clear the FIFO, discard the data, suppress pc_adv and go to IDLE.
REQ-023 In DROP, imem_ack SHALL be consumed without a push or pc_adv, then the FSM goes to IDLE; redirect in DROP keeps DROP.
REQ-024 id_valid SHALL equal FIFO non-empty; a pop SHALL occur when id_valid=1 and id_ready=1.
REQ-025 A push and a pop in the same cycle SHALL leave the count unchanged, with the head advancing correctly.
REQ-026 Redirect SHALL take priority over pop and push; entries popped in a redirect cycle are discarded by decode's own flush.
REQ-027 A push SHALL never occur when the FIFO is full; an issue SHALL require count < BUF_DEPTH at IDLE exit.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 On rst=1 at a clock edge: FSM->IDLE, FIFO empty, imem_req=0, pc_adv=0, id_valid=0, imem_addr=0, id_inst=0, id_pc=0.
REQ-030 Reset during WAIT or DROP SHALL abandon the request; any later stray ack SHALL be ignored per REQ-028.
REQ-031 rst SHALL take priority over redirect, ack and id_ready.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, BUF_DEPTH default and the fetch-entry type {pc[31:0],inst[31:0]}.
REQ-033 The FIFO SHALL be a sub-module fetch_fifo with push, pop, flush, full, empty, count and head data, instantiated once.

Verification
REQ-034 Reset, then pc_in=0x0, ack 1 cycle after req, id_ready=1 -> imem_addr 0x0, pc_adv pulse, id_valid with id_pc=0x0, id_inst=rdata; next request at addr 0x4.
REQ-035 id_ready=0, zero-wait memory -> exactly 2 entries (pc 0x0, 0x4); imem_req stays 0 afterward; raise id_ready -> entries in order, fetching resumes.
REQ-036 redirect in WAIT with pc_in->0x100, ack 3 cycles later -> FIFO empty, no pc_adv, data dropped; next request addr 0x100.
REQ-037 redirect coincident with ack -> no push, no pc_adv, FSM in IDLE; next imem_addr equals the new pc_in.
REQ-038 FIFO holds 1 entry, simultaneous pop and push -> count stays 1, id_pc steps to the new entry.
REQ-039 rst mid-WAIT, then ack with req=0 -> all outputs 0 and no push; normal fetch from pc_in follows.
